// File: rtl/counter_checker_pkg.sv
// Shared types and constants for the counter_checker monitor: FSM state
// encoding, counter widths, the "no error yet" sentinel and saturating
// increment helpers used by the top level.
package counter_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 8;
    localparam int CYC_CNT_W = 16;

    localparam logic [CYC_CNT_W-1:0] NO_ERR = 16'hFFFF;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [ERR_CNT_W-1:0] satIncErr(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + ERR_CNT_W'(1);
    endfunction

    // Same saturating behaviour for the wider checked-cycle counter.
    function automatic logic [CYC_CNT_W-1:0] satIncCyc(input logic [CYC_CNT_W-1:0] v);
        return (v == '1) ? v : v + CYC_CNT_W'(1);
    endfunction

endpackage

// File: rtl/counter_track.sv
// Per-channel expectation tracker. Holds the value the channel should show
// next cycle and flags when the observed value departs from it. The
// expectation is always re-derived from the observed value, so a glitch is
// reported on departure and again on return, never cascading further.
module counter_track #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_mismatch
);

    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] w_nextExp;

    assign w_nextExp  = i_cnt + STEP_V;
    assign o_mismatch = (i_cnt != r_exp);

    // Expected-value register: reload from the observed count whenever the
    // owning FSM samples this cycle, with the sum wrapping modulo 2^WIDTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exp <= '0;
        end else if (i_load) begin
            r_exp <= w_nextExp;
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Consumer-side monitor for a dual counter stream. Synchronises to the
// incoming counts, then checks every enabled cycle against the expected
// increment, accumulating sticky error status, saturating counts and the
// cycle of the first mismatch, and stops once channel 2 reaches TARGET.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP1  = 1,
    parameter int STEP2  = 1,
    parameter int TARGET = 208
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     cnt1_in,
    input  logic [WIDTH-1:0]     cnt2_in,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [CYC_CNT_W-1:0] cycle_cnt,
    output logic [CYC_CNT_W-1:0] first_err_cycle
);

    localparam logic [WIDTH-1:0] TARGET_V = WIDTH'(TARGET);

    state_t r_state;
    state_t w_nextState;

    logic w_load;
    logic w_check;
    logic w_mis1;
    logic w_mis2;
    logic w_mismatch;
    logic w_hitTarget;

    logic                 r_done;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_errCnt;
    logic [CYC_CNT_W-1:0] r_cycleCnt;
    logic [CYC_CNT_W-1:0] r_firstErrCycle;

    counter_track #(
        .WIDTH (WIDTH),
        .STEP  (STEP1)
    ) u_track1 (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_cnt      (cnt1_in),
        .o_mismatch (w_mis1)
    );

    counter_track #(
        .WIDTH (WIDTH),
        .STEP  (STEP2)
    ) u_track2 (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_cnt      (cnt2_in),
        .o_mismatch (w_mis2)
    );

    assign w_mismatch  = w_check && (w_mis1 || w_mis2);
    assign w_hitTarget = w_check && (cnt2_in == TARGET_V);

    // State register; reset drops the monitor back to IDLE immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the load/check strobes for the current state.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_check     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_load      = 1'b1;
                    w_nextState = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (en) begin
                    w_load  = 1'b1;
                    w_check = 1'b1;
                    if (cnt2_in == TARGET_V) begin
                        w_nextState = ST_DONE;
                    end
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_nextState = ST_DONE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Result registers: only a checked cycle may change them, which also
    // freezes everything once DONE is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_errCnt        <= '0;
            r_cycleCnt      <= '0;
            r_firstErrCycle <= NO_ERR;
        end else if (w_check) begin
            r_cycleCnt <= satIncCyc(r_cycleCnt);
            if (w_mismatch) begin
                r_err    <= 1'b1;
                r_errCnt <= satIncErr(r_errCnt);
                if (!r_err) begin
                    r_firstErrCycle <= r_cycleCnt;
                end
            end
            if (w_hitTarget) begin
                r_done <= 1'b1;
            end
        end
    end

    assign done            = r_done;
    assign err             = r_err;
    assign err_cnt         = r_errCnt;
    assign cycle_cnt       = r_cycleCnt;
    assign first_err_cycle = r_firstErrCycle;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: a vector table covering sync, glitch,
// enable-gap and TARGET-in-sync-cycle behaviour, followed by hand-written
// sequences for the long clean run, wrap, target-with-error and async reset.
module tb_counter_checker;

   logic        clk;
   logic        rst;
   logic        en;
   logic [7:0]  cnt1;
   logic [7:0]  cnt2;
   logic        done;
   logic        err;
   logic [7:0]  errCnt;
   logic [15:0] cycleCnt;
   logic [15:0] firstErrCycle;

   int checkCount;
   int failCount;

   typedef struct {
      bit          doRst;
      logic        en;
      logic [7:0]  c1;
      logic [7:0]  c2;
      logic        eDone;
      logic        eErr;
      logic [7:0]  eErrCnt;
      logic [15:0] eCyc;
      logic [15:0] eFirst;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs[NVEC];

   counter_checker dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .cnt1_in         (cnt1),
      .cnt2_in         (cnt2),
      .done            (done),
      .err             (err),
      .err_cnt         (errCnt),
      .cycle_cnt       (cycleCnt),
      .first_err_cycle (firstErrCycle)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(input bit r, input logic e, input logic [7:0] a, input logic [7:0] b,
                               input logic d, input logic er, input logic [7:0] ec,
                               input logic [15:0] cy, input logic [15:0] fe);
      vec_t v;
      v.doRst = r; v.en = e; v.c1 = a; v.c2 = b;
      v.eDone = d; v.eErr = er; v.eErrCnt = ec; v.eCyc = cy; v.eFirst = fe;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkOutput(input string name, input logic eDone, input logic eErr,
                              input logic [7:0] eErrCnt, input logic [15:0] eCyc,
                              input logic [15:0] eFirst);
      cmp({name, ".done"}, {15'd0, done}, {15'd0, eDone});
      cmp({name, ".err"}, {15'd0, err}, {15'd0, eErr});
      cmp({name, ".err_cnt"}, {8'd0, errCnt}, {8'd0, eErrCnt});
      cmp({name, ".cycle_cnt"}, cycleCnt, eCyc);
      cmp({name, ".first_err_cycle"}, firstErrCycle, eFirst);
   endtask

   task automatic applyStimulus(input logic e, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      en   = e;
      cnt1 = a;
      cnt2 = b;
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut(input int cycles);
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      repeat (cycles) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Main directed sequence.
   initial begin
      checkCount = 0;
      failCount  = 0;
      rst  = 1'b0;
      en   = 1'b0;
      cnt1 = '0;
      cnt2 = '0;

      vecs[0]  = mk(1, 0,   0,   0, 0, 0, 0, 0, 16'hFFFF);
      vecs[1]  = mk(0, 1,  10,  10, 0, 0, 0, 0, 16'hFFFF);
      vecs[2]  = mk(0, 1,  11,  11, 0, 0, 0, 1, 16'hFFFF);
      vecs[3]  = mk(0, 1,  99,  12, 0, 1, 1, 2, 16'd1);
      vecs[4]  = mk(0, 1,  13,  13, 0, 1, 2, 3, 16'd1);
      vecs[5]  = mk(0, 1,  14,  14, 0, 1, 2, 4, 16'd1);
      vecs[6]  = mk(1, 0,   0,   0, 0, 0, 0, 0, 16'hFFFF);
      vecs[7]  = mk(0, 1,   5,   5, 0, 0, 0, 0, 16'hFFFF);
      vecs[8]  = mk(0, 1,   6,   6, 0, 0, 0, 1, 16'hFFFF);
      vecs[9]  = mk(0, 0,  20,  20, 0, 0, 0, 1, 16'hFFFF);
      vecs[10] = mk(0, 0,  30,  30, 0, 0, 0, 1, 16'hFFFF);
      vecs[11] = mk(0, 0,  39,  39, 0, 0, 0, 1, 16'hFFFF);
      vecs[12] = mk(0, 0,  40,  40, 0, 0, 0, 1, 16'hFFFF);
      vecs[13] = mk(0, 1,  41,  41, 0, 0, 0, 1, 16'hFFFF);
      vecs[14] = mk(0, 1,  42,  42, 0, 0, 0, 2, 16'hFFFF);
      vecs[15] = mk(1, 0,   0,   0, 0, 0, 0, 0, 16'hFFFF);
      vecs[16] = mk(0, 1,   7, 208, 0, 0, 0, 0, 16'hFFFF);
      vecs[17] = mk(0, 1,   8, 209, 0, 0, 0, 1, 16'hFFFF);

      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].doRst) begin
            resetDut(3);
         end else begin
            applyStimulus(vecs[i].en, vecs[i].c1, vecs[i].c2);
         end
         checkOutput($sformatf("vec%0d", i), vecs[i].eDone, vecs[i].eErr,
                     vecs[i].eErrCnt, vecs[i].eCyc, vecs[i].eFirst);
      end

      resetDut(3);
      for (int i = 0; i <= 208; i++) begin
         applyStimulus(1'b1, 8'(i), 8'(i));
         if (i == 207) checkOutput("clean.pre", 0, 0, 0, 16'd207, 16'hFFFF);
      end
      checkOutput("clean.done", 1, 0, 0, 16'd208, 16'hFFFF);
      applyStimulus(1'b1, 8'd0, 8'd0);
      checkOutput("clean.frozen", 1, 0, 0, 16'd208, 16'hFFFF);

      resetDut(3);
      for (int k = 0; k <= 108; k++) begin
         applyStimulus(1'b1, 8'(250 + k), 8'(100 + k));
         if (k == 7) checkOutput("wrap.after255", 0, 0, 0, 16'd7, 16'hFFFF);
      end
      checkOutput("wrap.done", 1, 0, 0, 16'd108, 16'hFFFF);

      resetDut(3);
      for (int v = 200; v <= 206; v++) begin
         applyStimulus(1'b1, 8'(v), 8'(v));
      end
      checkOutput("tgt.pre", 0, 0, 0, 16'd6, 16'hFFFF);
      applyStimulus(1'b1, 8'd207, 8'd208);
      checkOutput("tgt.hit", 1, 1, 1, 16'd7, 16'd6);
      applyStimulus(1'b1, 8'd50, 8'd60);
      applyStimulus(1'b1, 8'd90, 8'd3);
      applyStimulus(1'b0, 8'd1, 8'd1);
      checkOutput("tgt.frozen", 1, 1, 1, 16'd7, 16'd6);

      resetDut(3);
      applyStimulus(1'b1, 8'd0, 8'd0);
      applyStimulus(1'b1, 8'd1, 8'd1);
      applyStimulus(1'b1, 8'd9, 8'd2);
      applyStimulus(1'b1, 8'd20, 8'd3);
      applyStimulus(1'b1, 8'd30, 8'd4);
      checkOutput("arst.pre", 0, 1, 3, 16'd4, 16'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 checkOutput("arst.immediate", 0, 0, 0, 16'd0, 16'hFFFF);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      applyStimulus(1'b1, 8'd100, 8'd100);
      checkOutput("arst.sync", 0, 0, 0, 16'd0, 16'hFFFF);
      applyStimulus(1'b1, 8'd101, 8'd101);
      checkOutput("arst.check", 0, 0, 0, 16'd1, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/counter_checker.md
# counter_checker

Self-checking monitor at the consumer end of the dual 8-bit counter interface driven by `counters`. It samples `cnt1_out`/`cnt2_out` every clock and tracks the expected next value of each channel. It counts mismatches, records the cycle of the first one, and raises `done` when channel 2 reaches a target value. It replaces ad-hoc `$display`/`$finish` checking in mixed-language testbenches and can also be synthesized as an on-chip health monitor.

## Interface
Parameters:
- `WIDTH`, 8, width of each counter channel
- `STEP1`, 1, expected per-cycle increment of channel 1 (mod 2^WIDTH)
- `STEP2`, 1, expected per-cycle increment of channel 2 (mod 2^WIDTH)
- `TARGET`, 208, channel-2 value that completes the check

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  sample enable; low means the counters are not to be checked this cycle
- `cnt1_in`  in  WIDTH  channel-1 counter value
- `cnt2_in`  in  WIDTH  channel-2 counter value
- `done`  out  1  sticky; TARGET was seen on channel 2
- `err`  out  1  sticky; at least one mismatch was seen
- `err_cnt`  out  8  mismatch count, saturating at 255
- `cycle_cnt`  out  16  number of checked cycles, saturating at 0xFFFF
- `first_err_cycle`  out  16  `cycle_cnt` value at the first mismatch; 0xFFFF if there has been none

## Operation
- The FSM has three states: IDLE, CHECK and DONE.
- Reset (rst=0, asynchronous) sets the FSM to IDLE and sets these output values:
  - `done`=0, `err`=0, `err_cnt`=0, `cycle_cnt`=0
  - `first_err_cycle`=0xFFFF
  - expected registers `exp1`=0, `exp2`=0
- IDLE, en=1: load `exp1`=cnt1_in+STEP1 and `exp2`=cnt2_in+STEP2, then go to CHECK. No compare is made in this cycle.
- IDLE, en=0: stay in IDLE.
- CHECK, en=1:
  - Mismatch means (cnt1_in≠exp1) OR (cnt2_in≠exp2).
  - On a mismatch: `err`←1, and `err_cnt` increments with saturation. If `err` was 0, `first_err_cycle`←`cycle_cnt` (value before this cycle's increment).
  - `cycle_cnt` increments with saturation.
  - Expectations resync to the observed values: `exp1`←cnt1_in+STEP1, `exp2`←cnt2_in+STEP2. A single-cycle glitch therefore produces exactly 2 mismatches: the departure and the return.
  - If cnt2_in==TARGET, go to DONE and set `done`←1. Mismatch accounting for that same cycle still applies.
- CHECK, en=0: go to IDLE. No compare is made, and counts are held. The next en=1 cycle re-syncs.
- DONE: all registers are frozen until reset, whatever the value of `en`. TARGET seen in IDLE does not set `done`; only a checked cycle in CHECK can.
- Arithmetic: all expectation sums are mod 2^WIDTH, so 255+1 = 0 at WIDTH=8 and the wrap is not a mismatch. Counters saturate and never wrap.
- If reset is asserted mid-operation, all state is lost immediately with no drain. After release the block starts in IDLE.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Latency: inputs sampled on edge N are reflected in the outputs after edge N; they are visible in cycle N+1.
- `done` is asserted in the cycle after TARGET is sampled.
- Minimum checked stream:
  - 1 sync cycle, then checking begins on the 2nd consecutive en=1 cycle.
  - A TARGET appearing only in the sync cycle is ignored.
- Reset release must be synchronous to `clk` at system level. The block does not synchronize it internally.

## Structure
- Package `counter_checker_pkg` holds:
  - the FSM state typedef (IDLE/CHECK/DONE)
  - the `ERR_CNT_W`=8 and `CYC_CNT_W`=16 constants
  - the `NO_ERR`=16'hFFFF sentinel
- Sub-module `counter_track`, instantiated once per channel:
  - parameters WIDTH and STEP
  - holds the expected-value register and its load/resync logic
  - outputs a per-channel `mismatch` bit
- The top level holds the FSM, the saturating counters and first-error capture.

## Test plan
- Clean run: reset 3 cycles, then en=1 with cnt1=cnt2 counting 0,1,2… → `err`=0, `err_cnt`=0, `done`=1 one cycle after 208 is sampled, `cycle_cnt`=208, `first_err_cycle`=0xFFFF.
- Wrap: cnt1 runs 250…255,0,1…, cnt2 runs 100…208 → no mismatch at the 255→0 transition; `done`=1.
- Glitch: cnt1 stream 10,11,99,13,14 → `err_cnt`=2, `first_err_cycle`=1, `err`=1.
- Enable gap: en=1 for values 5,6, en=0 for 4 cycles while the counter jumps to 40, then en=1 for 41,42 → `err_cnt`=0 and `cycle_cnt`=2 (one checked cycle in each burst).
- Target with error: cnt2 jumps 206→208 → `err_cnt`=1 and `done`=1 in the same cycle; subsequent mismatches leave the counts frozen.
- Async reset mid-CHECK: pull rst low between edges with err_cnt=3 → all outputs return to reset values immediately, without waiting for a clock edge; after release the block resyncs on the first en=1 cycle.
